// File: rtl/pkt_ingress_tagger.sv
// pkt_ingress_tagger: tags packets with their header flow ID, truncates overlong packets and
// drives the buffer write port through a registered two-entry skid buffer.
module pkt_ingress_tagger #(
  parameter int DATA_WIDTH = 32,
  parameter int SB_WIDTH   = 10,
  parameter int FLOW_LANE  = 1,
  parameter int MAX_BEATS  = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic                  m_wlast,
  output logic [SB_WIDTH-1:0]   m_wsideband,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_trunc_cnt,
  output logic                  trunc_pulse
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;
  state_t state, state_n;
  logic [CW-1:0] beat_cnt, cnt_n;
  logic [7:0] flow_id, flow_n;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [SB_WIDTH-1:0] sk_sb, in_sb;
  logic sk_last, sk_valid, sk_valid_n;
  logic acc, fwd, trunc, in_last, hs, load;
  always_comb begin
    acc        = s_tvalid && s_tready;
    fwd        = acc && state != DROP;
    flow_n     = state == HEAD ? s_tdata[8*FLOW_LANE +: 8] : flow_id;
    cnt_n      = state == HEAD ? CW'(1) : beat_cnt + CW'(1);
    trunc      = fwd && !s_tlast && cnt_n == CW'(MAX_BEATS);
    in_last    = s_tlast || trunc;
    in_sb      = SB_WIDTH'(flow_n);
    hs         = m_wvalid && m_wready;
    load       = hs || !m_wvalid;
    sk_valid_n = load ? 1'b0 : sk_valid || fwd;
    state_n    = !acc ? state : s_tlast ? HEAD : (state == DROP || trunc) ? DROP : BODY;
  end
  // The skid register only fills while the main register is stalled; s_tready keeps it from overflowing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= HEAD;
      beat_cnt       <= '0;
      flow_id        <= '0;
      m_wdata        <= '0;
      m_wvalid       <= 1'b0;
      m_wlast        <= 1'b0;
      m_wsideband    <= '0;
      sk_data        <= '0;
      sk_sb          <= '0;
      sk_last        <= 1'b0;
      sk_valid       <= 1'b0;
      s_tready       <= 1'b0;
      trunc_pulse    <= 1'b0;
      stat_pkt_cnt   <= '0;
      stat_trunc_cnt <= '0;
    end else begin
      state <= state_n;
      if (fwd) begin
        beat_cnt <= cnt_n;
        flow_id  <= flow_n;
      end
      if (load) begin
        m_wvalid <= sk_valid || fwd;
        if (sk_valid) {m_wdata, m_wlast, m_wsideband} <= {sk_data, sk_last, sk_sb};
        else if (fwd) {m_wdata, m_wlast, m_wsideband} <= {s_tdata, in_last, in_sb};
      end else if (fwd) begin
        {sk_data, sk_last, sk_sb} <= {s_tdata, in_last, in_sb};
      end
      sk_valid       <= sk_valid_n;
      s_tready       <= state_n == DROP || !sk_valid_n;
      trunc_pulse    <= trunc;
      stat_trunc_cnt <= stat_trunc_cnt + {31'b0, trunc};
      stat_pkt_cnt   <= stat_pkt_cnt + {31'b0, hs && m_wlast};
    end
  end
endmodule

// File: tb/tb_pkt_ingress_tagger.sv
// tb_pkt_ingress_tagger: randomized scoreboard bench; a packet-level model predicts every output beat.
module tb_pkt_ingress_tagger;
  localparam int DW = 32, SBW = 10, LANE = 1, MAXB = 64;
  typedef logic [DW+SBW:0] beat_t;
  logic clk = 0, rstn, s_tvalid, s_tready, s_tlast, m_wvalid, m_wready = 1, m_wlast, trunc_pulse;
  logic [DW-1:0] s_tdata, m_wdata;
  logic [SBW-1:0] m_wsideband;
  logic [31:0] stat_pkt_cnt, stat_trunc_cnt;
  logic up = 0;
  int n_cmp = 0, n_fail = 0, mode = 0, gaps = 0;

  pkt_ingress_tagger #(.DATA_WIDTH(DW), .SB_WIDTH(SBW), .FLOW_LANE(LANE), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast), .m_wsideband(m_wsideband), .stat_pkt_cnt(stat_pkt_cnt),
    .stat_trunc_cnt(stat_trunc_cnt), .trunc_pulse(trunc_pulse));

  always #5 clk = ~clk;
  always @(posedge clk or negedge rstn) up <= rstn;
  always @(posedge clk) begin
    #1;
    m_wready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : 1'b0;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: packet beat index, drop flag and outstanding-beat count.
  beat_t q[$];
  beat_t exp_b;
  logic [DW+SBW:0] held;
  logic [7:0] flow;
  logic stall = 0, drop = 0, e_pulse = 0, last;
  int occ = 0, idx = 0, e_pkt = 0, e_trunc = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete(); occ = 0; idx = 0; drop = 0; e_pkt = 0; e_trunc = 0; e_pulse = 0; stall = 0;
      chk("reset_outputs", {m_wvalid, m_wlast, m_wdata, m_wsideband, s_tready, trunc_pulse,
                            stat_pkt_cnt, stat_trunc_cnt}, 0);
    end else if (up) begin
      chk("m_wvalid", m_wvalid, occ > 0);
      chk("s_tready", s_tready, drop || occ < 2);
      chk("trunc_pulse", trunc_pulse, e_pulse);
      chk("stat_pkt_cnt", stat_pkt_cnt, e_pkt);
      chk("stat_trunc_cnt", stat_trunc_cnt, e_trunc);
      if (stall) chk("stall_hold", {m_wlast, m_wsideband, m_wdata}, held);
      stall = m_wvalid && !m_wready;
      held = {m_wlast, m_wsideband, m_wdata};
      e_pulse = 0;
      if (m_wvalid && m_wready) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_beat: got %0h expected no beat", m_wdata);
        end else begin
          exp_b = q.pop_front();
          chk("out_beat", {m_wlast, m_wsideband, m_wdata}, exp_b);
          if (exp_b[DW+SBW]) e_pkt++;
        end
        occ--;
      end
      if (s_tvalid && s_tready) begin
        if (drop) begin
          if (s_tlast) drop = 0;
        end else begin
          if (idx == 0) flow = s_tdata[8*LANE +: 8];
          last = s_tlast || idx == MAXB - 1;
          q.push_back({last, SBW'(flow), s_tdata});
          occ++;
          if (last && !s_tlast) begin drop = 1; e_trunc++; e_pulse = 1; end
          idx = last ? 0 : idx + 1;
        end
      end
    end
  end

  task automatic send(input int len, input logic [7:0] fl, input int stop);
    logic [DW-1:0] d;
    logic a;
    int w;
    for (int b = 0; b < len && b < stop; b++) begin
      d = $urandom;
      if (b == 0) d[8*LANE +: 8] = fl;
      while (gaps != 0 && $urandom % 4 == 0) begin
        s_tvalid = 0;
        @(posedge clk); #1;
      end
      s_tvalid = 1; s_tdata = d; s_tlast = b == len - 1;
      w = 0;
      do begin
        @(negedge clk); a = s_tready;
        @(posedge clk); #1; w++;
      end while (!a && w < 2000);
      if (!a) begin
        n_cmp++; n_fail++;
        $display("FAIL input_timeout: got s_tready 0 expected 1 within 2000 cycles");
      end
    end
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || m_wvalid) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
    end
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1; s_tvalid = 0; s_tlast = 0; s_tdata = 0;
    #3 rstn = 0; s_tvalid = 1; s_tdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 chk("rst_tready", s_tready, 0);
    #1 rstn = 1;
    @(posedge clk); #1;
    chk("tready_rise", s_tready, 1);
    s_tvalid = 0;
    send(20, 8'h5A, 20); drain();
    chk("basic_pkts", stat_pkt_cnt, 1);
    mode = 1;
    send($urandom_range(4, 24), 8'h01, 99);
    send($urandom_range(4, 24), 8'h80, 99);
    send($urandom_range(4, 24), 8'hFF, 99);
    drain();
    chk("bp_pkts", stat_pkt_cnt, 4);
    send(70, 8'hC3, 70); send(5, 8'h33, 5); drain();
    chk("trunc_pkts", stat_pkt_cnt, 6);
    chk("trunc_cnt", stat_trunc_cnt, 1);
    send(64, 8'h64, 64); drain();
    chk("exact_max_trunc", stat_trunc_cnt, 1);
    chk("exact_max_pkts", stat_pkt_cnt, 7);
    send(1, 8'h9E, 1); drain();
    chk("single_pkts", stat_pkt_cnt, 8);
    gaps = 1;
    repeat (10) begin
      mode = $urandom % 2;
      send($urandom_range(1, 80), 8'($urandom), 999);
    end
    drain();
    gaps = 0; mode = 1;
    send(30, 8'h2B, 10);
    mode = 2;
    repeat (2) @(posedge clk); #1;
    s_tvalid = 1; s_tdata = $urandom; s_tlast = 0;
    @(posedge clk); #1;
    s_tvalid = 0;
    chk("pre_rst_valid", m_wvalid, 1);
    rstn = 0;
    #1 chk("rst_valid_drop", m_wvalid, 0);
    mode = 0;
    repeat (2) @(posedge clk); #2;
    rstn = 1;
    @(posedge clk); #1;
    send(8, 8'h77, 8); drain();
    chk("post_rst_pkts", stat_pkt_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_ingress_tagger.md
# pkt_ingress_tagger

Ingress stage sitting directly upstream of `buffer_top` write port. Accepts raw AXI-Stream packets, extracts the flow ID byte from the header beat and drives it as constant sideband for the whole packet. Enforces a maximum packet length by truncating and discarding overlong tails. Presents a registered, full-throughput, skid-buffered AXI-S master to the buffer's `s_w*` port.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits (multiple of 8).
- `SB_WIDTH`, 10: sideband width; must be >= 8.
- `FLOW_LANE`, 1: byte lane of the first beat carrying the flow ID.
- `MAX_BEATS`, 64: maximum beats per forwarded packet (>= 1).

- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `s_tdata` in DATA_WIDTH: input packet data.
- `s_tvalid` in 1: input beat valid.
- `s_tready` out 1: input beat accepted when `s_tvalid && s_tready`.
- `s_tlast` in 1: last beat of input packet.
- `m_wdata` out DATA_WIDTH: to buffer `s_wdata`.
- `m_wvalid` out 1: to buffer `s_wvalid`.
- `m_wready` in 1: from buffer `s_wready`.
- `m_wlast` out 1: to buffer `s_wlast`.
- `m_wsideband` out SB_WIDTH: to buffer `s_wsideband`; `{(SB_WIDTH-8)'b0, flow_id[7:0]}`.
- `stat_pkt_cnt` out 32: packets forwarded (counted at output `m_wlast` handshake).
- `stat_trunc_cnt` out 32: packets truncated.
- `trunc_pulse` out 1: one-cycle pulse when a truncation occurs.

## Operation
- Input FSM states: HEAD, BODY, DROP. Reset state HEAD.
- HEAD: on accepted beat, latch `flow_id = s_tdata[8*FLOW_LANE +: 8]`, set `beat_cnt = 1`, forward beat. If `s_tlast`, stay in HEAD. Otherwise, if `MAX_BEATS == 1`, truncate. Otherwise go to BODY.
- BODY: on accepted beat, `beat_cnt++`, forward beat. `s_tlast` -> HEAD.
- BODY truncation: when the accepted beat makes `beat_cnt == MAX_BEATS` and `s_tlast == 0`:
  - forward that beat with `m_wlast = 1`;
  - pulse `trunc_pulse`, increment `stat_trunc_cnt`;
  - go to DROP.
- DROP: `s_tready = 1` regardless of output; accepted beats are discarded; `s_tlast` -> HEAD.
- A packet of exactly MAX_BEATS beats ending with `s_tlast` is not truncated.
- `beat_cnt` width is `$clog2(MAX_BEATS+1)`; it never exceeds MAX_BEATS.
- Sideband is stored with each beat in the skid buffer, so `m_wsideband` is constant across every beat of an output packet.
- Counters wrap modulo 2^32; both are cleared only by reset.
- Output order equals input order; no beat is duplicated or reordered.

## Timing
- Output is a 2-entry skid buffer (main register + skid register), all outputs registered.
- Latency: an accepted input beat appears on `m_w*` on the next cycle when the buffer is empty.
- Throughput: 1 beat/cycle while `m_wready = 1`.
- `s_tready` (outside DROP) is registered and equals "skid register empty". It deasserts the cycle after a beat is captured into the skid register while the output is stalled. It reasserts the cycle after the output handshake drains the skid register.
- Output handshake rules:
  - `m_wvalid` never drops without a handshake;
  - `m_wdata`, `m_wlast` and `m_wsideband` are held stable while `m_wvalid && !m_wready`.
- Simultaneous input accept and output handshake with the skid register empty: pass-through, no skid use.
- Reset (async assert) values:
  - `m_wvalid = 0`, `m_wlast = 0`, `m_wdata = 0`, `m_wsideband = 0`;
  - `s_tready = 0`, `trunc_pulse = 0`, both counters 0;
  - FSM in HEAD, skid buffer empty.
- `s_tready` rises on the first `clk` edge after `rstn` deasserts.
- Reset mid-packet: the partial packet is lost in both buffer and FSM. Downstream sees `m_wvalid` fall asynchronously and must itself be in reset (shared `rstn`).
- `trunc_pulse` is high exactly one cycle, coincident with the cycle after the truncating beat is accepted.

## Test plan
- Reset: hold `rstn = 0` with `s_tvalid = 1`. Required:
  - all outputs are at their reset values;
  - `s_tready` goes to 1 one cycle after release.
- Basic: 20-beat packet, byte lane 1 of beat 0 = 0x5A, `m_wready = 1`. Required:
  - 20 output beats, first one cycle after the first input accept;
  - `m_wsideband = 0x05A` on all beats;
  - `m_wlast` on beat 20 only;
  - `stat_pkt_cnt = 1`.
- Backpressure: 3 back-to-back packets (flows 0x01, 0x80, 0xFF) with random `m_wready`. Required:
  - data and sideband on output match input exactly;
  - `s_tready` low only while the skid register is full;
  - output signals stable during every stall;
  - `stat_pkt_cnt = 3`.
- Truncation: `MAX_BEATS = 64`, 70-beat packet followed by a 5-beat packet with flow 0x33. Required:
  - 64 beats out, `m_wlast` on the 64th;
  - the 6 tail beats are accepted with `s_tready = 1` and dropped;
  - `trunc_pulse` fires once, `stat_trunc_cnt = 1`;
  - the next packet is 5 beats with sideband 0x033.
- Boundaries:
  - a packet of exactly 64 beats gives no truncation and `stat_trunc_cnt` is unchanged;
  - a single-beat packet gives one beat with `m_wlast = 1` and correct sideband.
- Reset mid-packet: assert `rstn` at beat 10 of a 30-beat packet while `m_wready = 0`. Required:
  - `m_wvalid` drops immediately;
  - after release, a new 8-beat packet is forwarded intact;
  - `stat_pkt_cnt = 1`.
